// File: rtl/harris_ssd_accum.sv
// Windowed sum of squared centre/neighbour differences for the Harris corner datapath.
// One centre pixel per window, N_TAPS neighbours streamed in, saturating energy plus corner flag out.
module harris_ssd_accum #(
    parameter int PIX_W  = 8,
    parameter int N_TAPS = 8,
    parameter int ACC_W  = 14,
    parameter int THRESH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] in_center,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_target,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] e_out,
    output logic             corner,
    output logic             sat,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_TAPS + 1);
    localparam int SQ_W  = 2 * PIX_W;
    localparam int SUM_W = ACC_W + SQ_W;
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] THRESH_C = ACC_W'(THRESH);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    logic [PIX_W-1:0]   center_r;
    logic [CNT_W-1:0]   tap_cnt_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   e_out_r;
    logic               corner_r;
    logic               sat_r;

    logic               s1_v_r;
    logic               s1_last_r;
    logic [PIX_W-1:0]   s1_d_r;
    logic               s2_v_r;
    logic               s2_last_r;
    logic [SQ_W-1:0]    s2_sq_r;
    logic [ACC_W-1:0]   acc_r;
    logic               win_sat_r;
    logic               done_r;

    logic               xfer_s;
    logic               last_tap_s;
    logic               start_acc_s;
    logic [PIX_W-1:0]   diff_s;
    logic [SUM_W-1:0]   sum_s;
    logic               clamp_s;

    // Handshake decode, absolute difference and wide saturating sum.
    always_comb begin
        xfer_s      = in_valid && in_ready_r;
        last_tap_s  = (tap_cnt_r == LAST_TAP);
        start_acc_s = (state_r == IDLE) && start;
        if (in_target >= center_r) begin
            diff_s = in_target - center_r;
        end else begin
            diff_s = center_r - in_target;
        end
        sum_s   = SUM_W'(acc_r) + SUM_W'(s2_sq_r);
        clamp_s = (sum_s > SUM_W'(ACC_MAX));
    end

    // Control FSM, three-stage datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            center_r    <= '0;
            tap_cnt_r   <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            e_out_r     <= '0;
            corner_r    <= 1'b0;
            sat_r       <= 1'b0;
            s1_v_r      <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_d_r      <= '0;
            s2_v_r      <= 1'b0;
            s2_last_r   <= 1'b0;
            s2_sq_r     <= '0;
            acc_r       <= '0;
            win_sat_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            s1_v_r    <= xfer_s;
            s1_last_r <= xfer_s && last_tap_s;
            s1_d_r    <= diff_s;
            s2_v_r    <= s1_v_r;
            s2_last_r <= s1_v_r && s1_last_r;
            s2_sq_r   <= SQ_W'(s1_d_r) * SQ_W'(s1_d_r);
            done_r    <= s2_v_r && s2_last_r;

            // The pipeline is empty whenever a start can be accepted, so clearing wins.
            if (start_acc_s) begin
                acc_r     <= '0;
                win_sat_r <= 1'b0;
            end else if (s2_v_r) begin
                acc_r     <= clamp_s ? ACC_MAX : sum_s[ACC_W-1:0];
                win_sat_r <= win_sat_r | clamp_s;
            end else begin
                acc_r     <= acc_r;
                win_sat_r <= win_sat_r;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        center_r   <= in_center;
                        tap_cnt_r  <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        tap_cnt_r <= tap_cnt_r + CNT_W'(1);
                        if (last_tap_s) begin
                            in_ready_r <= 1'b0;
                            state_r    <= DRAIN;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                DRAIN: begin
                    // Stay here through the out_valid cycle so busy covers it.
                    if (out_valid_r) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else if (done_r) begin
                        e_out_r     <= acc_r;
                        corner_r    <= (acc_r >= THRESH_C);
                        sat_r       <= win_sat_r;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign e_out     = e_out_r;
    assign corner    = corner_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_harris_ssd_accum.sv
// Scoreboard bench for harris_ssd_accum: expected windows queued at start, checked on out_valid.
module tb_harris_ssd_accum;

    localparam int PIX_W  = 8;
    localparam int N      = 8;
    localparam int ACC_W  = 14;
    localparam int THRESH = 1024;
    localparam int E_MAX  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PIX_W-1:0] in_center;
    logic             in_valid;
    logic [PIX_W-1:0] in_target;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] e_out;
    logic             corner;
    logic             sat;
    logic             busy;

    typedef struct {
        int e;
        int c;
        int s;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ov_count = 0;

    harris_ssd_accum #(
        .PIX_W (PIX_W),
        .N_TAPS(N),
        .ACC_W (ACC_W),
        .THRESH(THRESH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_center(in_center),
        .in_valid (in_valid),
        .in_target(in_target),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .e_out    (e_out),
        .corner   (corner),
        .sat      (sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            ov_count++;
            if (sb_q.size() == 0) begin
                check_val("spurious_out_valid", 1, 0);
            end else begin
                mon_x = sb_q.pop_front();
                check_val("e_out", int'(e_out), mon_x.e);
                check_val("corner", int'(corner), mon_x.c);
                check_val("sat", int'(sat), mon_x.s);
            end
        end
    end

    task automatic run_window(input int center, input int tg[8], input int gap_pct,
                              input bit extra_start);
        int   total;
        int   d;
        int   waitc;
        int   lat;
        int   ov0;
        exp_t x;
        total = 0;
        for (int i = 0; i < N; i++) begin
            d = tg[i] - center;
            if (d < 0) d = -d;
            total += d * d;
        end
        x.e = (total > E_MAX) ? E_MAX : total;
        x.s = (total > E_MAX) ? 1 : 0;
        x.c = (x.e >= THRESH) ? 1 : 0;
        sb_q.push_back(x);
        ov0 = ov_count;

        @(posedge clk); #1;
        start     = 1'b1;
        in_center = center[PIX_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);

        for (int i = 0; i < N; i++) begin
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_valid = 1'b0;
                start    = extra_start;
                in_target = $urandom_range(255, 0);
                repeat ($urandom_range(2, 1)) begin
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
            in_valid  = 1'b1;
            in_target = tg[i][PIX_W-1:0];
            waitc = 0;
            while (!in_ready && waitc < 50) begin
                @(posedge clk); #1;
                waitc++;
            end
            if (waitc >= 50) check_val("ready_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        check_val("in_ready_after_last", int'(in_ready), 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, 4);
        check_val("busy_in_out_cycle", int'(busy), 1);
        @(posedge clk); #1;
        check_val("busy_after_out", int'(busy), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val("one_out_valid", ov_count - ov0, 1);
        check_val("e_out_held", int'(e_out), x.e);
        check_val("idle_after_window", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov0;
        rst       = 1'b1;
        start     = 1'b0;
        in_center = '0;
        in_valid  = 1'b0;
        in_target = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready", int'(in_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_e_out", int'(e_out), 0);
        check_val("rst_out_valid", int'(out_valid), 0);

        // Reset in the middle of a window with samples still in the pipeline.
        ov0 = ov_count;
        @(posedge clk); #1;
        start     = 1'b1;
        in_center = 8'd0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_target = 8'd255;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_in_ready", int'(in_ready), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_out_valid", int'(out_valid), 0);
        check_val("mid_rst_e_out", int'(e_out), 0);
        check_val("mid_rst_corner", int'(corner), 0);
        check_val("mid_rst_sat", int'(sat), 0);
        repeat (10) @(posedge clk);
        #1;
        check_val("mid_rst_no_out", ov_count - ov0, 0);

        run_window(100, '{100, 101, 102, 103, 104, 105, 106, 107}, 0, 1'b0);
        run_window(200, '{190, 190, 190, 190, 190, 190, 190, 190}, 0, 1'b0);
        run_window(200, '{210, 210, 210, 210, 210, 210, 210, 210}, 0, 1'b0);
        run_window(0,   '{16, 16, 16, 16, 0, 0, 0, 0}, 0, 1'b0);
        run_window(0,   '{16, 16, 16, 15, 0, 0, 0, 0}, 0, 1'b0);
        run_window(0,   '{255, 255, 255, 255, 255, 255, 255, 255}, 0, 1'b0);
        run_window(100, '{100, 101, 102, 103, 104, 105, 106, 107}, 0, 1'b0);
        run_window(100, '{100, 101, 102, 103, 104, 105, 106, 107}, 50, 1'b1);
        run_window(37,  '{0, 255, 37, 80, 12, 200, 36, 38}, 40, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
